regfile_multiport: RTL and testbench

Parametrised integer register file for the single-cycle core, generalising the two-read/one-write register file to `NRD` read ports and configurable width and depth. It adds a hardwired-zero register 0, optional write-to-read bypass, and a sequential clear engine that zeroes the array after reset or on request. It sits between the decode stage, which drives the read addresses, and the writeback mux, which drives the write port.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_multiport_if.sv | 19 +
 rtl/regfile_rd_port.sv | 26 ++
 rtl/regfile_multiport.sv | 99 +++++++++
 tb/tb_regfile_multiport.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port integer register file.
package regfile_pkg;
  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;
endpackage

// File: rtl/regfile_multiport_if.sv
// Register-file bus: decode-side read addresses, writeback port, clear request and status.
interface regfile_multiport_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   A;
  logic [NRD*XLEN-1:0] RD;
  logic [AW-1:0]       A3;
  logic [XLEN-1:0]     WD3;
  logic                WE3;
  logic                clr_req;
  logic                ready;

  modport master (output A, A3, WD3, WE3, clr_req, input RD, ready);
  modport slave  (input A, A3, WD3, WE3, clr_req, output RD, ready);
endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero register, optional same-cycle write forwarding, array mux.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = RF_NREGS,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic [AW-1:0]         addr,
  input  rf_state_t             state,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [XLEN-1:0]       wd,
  input  logic [NREGS*XLEN-1:0] mem_flat,
  output logic [XLEN-1:0]       rd
);
  always_comb begin
    rd = '0;
    // Nothing is readable until the sweep has finished; address 0 is hardwired zero.
    if (state == RUN && addr != '0) begin
      if (BYPASS != 0 && we && wa == addr) rd = wd;
      else                                 rd = mem_flat[int'(addr)*XLEN +: XLEN];
    end
  end
endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file with NRD read ports, hardwired x0 and a post-reset clear sweep.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = RF_NREGS,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic              CLK,
  input logic              rst,
  regfile_multiport_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]       mem [1:NREGS-1];
  logic [NREGS*XLEN-1:0] mem_flat;

  rf_state_t       state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            ready_q, ready_d;

  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    if (bus.clr_req) begin
      state_d = CLEAR;
      ptr_d   = AW'(1);
      ready_d = 1'b0;
    end else if (state_q == CLEAR) begin
      // ptr holds at the top entry so it can never wrap onto register 0.
      if (ptr_q == AW'(NREGS - 1)) begin
        state_d = RUN;
        ready_d = 1'b1;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = ptr_q;
    mem_wd = '0;
    if (state_q == CLEAR) begin
      mem_we = 1'b1;
    end else if (bus.WE3 && !bus.clr_req && bus.A3 != '0) begin
      mem_we = 1'b1;
      mem_wa = bus.A3;
      mem_wd = bus.WD3;
    end
  end

  // Array has no reset so it stays RAM-inferable; the sweep provides the zeroing.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    mem_flat = '0;
    for (int r = 1; r < NREGS; r++) mem_flat[r*XLEN +: XLEN] = mem[r];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rd_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .BYPASS(BYPASS),
      .AW    (AW)
    ) u_port (
      .addr    (bus.A[i*AW +: AW]),
      .state   (state_q),
      .we      (bus.WE3),
      .wa      (bus.A3),
      .wd      (bus.WD3),
      .mem_flat(mem_flat),
      .rd      (bus.RD[i*XLEN +: XLEN])
    );
  end

  assign bus.ready = ready_q;
endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: one bypassing and one non-bypassing instance driven in lockstep.
module tb_regfile_multiport;
  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #5 CLK = ~CLK;

  regfile_multiport_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus0 ();
  regfile_multiport_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus1 ();

  regfile_multiport #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_byp (
    .CLK(CLK), .rst(rst), .bus(bus0));
  regfile_multiport #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_nob (
    .CLK(CLK), .rst(rst), .bus(bus1));

  typedef struct {
    logic [4:0]  a0, a1, a3;
    logic [31:0] wd;
    logic        we;
    logic [31:0] e0, e1;       // expected with bypass
    logic [31:0] n0, n1;       // expected without bypass
  } vec_t;

  typedef struct {
    logic [31:0] e0, e1, n0, n1;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic set_in(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a3,
                        input logic [31:0] wd, input logic we, input logic clr);
    bus0.A = {a1, a0};  bus1.A = {a1, a0};
    bus0.A3 = a3;       bus1.A3 = a3;
    bus0.WD3 = wd;      bus1.WD3 = wd;
    bus0.WE3 = we;      bus1.WE3 = we;
    bus0.clr_req = clr; bus1.clr_req = clr;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge CLK);
    set_in(5'd0, 5'd0, a, d, 1'b1, 1'b0);
    @(posedge CLK);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    @(negedge CLK);
    set_in(a, a, 5'd0, 32'd0, 1'b0, 1'b0);
    #2;
    chk({name, "_p0"}, bus0.RD[31:0], exp);
    chk({name, "_p1"}, bus0.RD[63:32], exp);
  endtask

  // Edges counted from the next rising edge until ready is seen high; 0 if never within bound.
  task automatic count_ready(output int n0, output int n1);
    n0 = 0; n1 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge CLK);
      #1;
      if (bus0.ready && n0 == 0) n0 = i;
      if (bus1.ready && n1 == 0) n1 = i;
      if (n0 != 0 && n1 != 0) break;
    end
  endtask

  initial begin
    int c0, c1;
    exp_t e;

    tbl[0] = '{5'd0, 5'd0, 5'd5, 32'h6,        1'b1, 32'h0,        32'h0,  32'h0,  32'h0};
    tbl[1] = '{5'd5, 5'd0, 5'd6, 32'hA,        1'b1, 32'h6,        32'h0,  32'h6,  32'h0};
    tbl[2] = '{5'd6, 5'd5, 5'd0, 32'h0,        1'b0, 32'hA,        32'h6,  32'hA,  32'h6};
    tbl[3] = '{5'd7, 5'd5, 5'd7, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'h6,  32'h0,  32'h6};
    tbl[4] = '{5'd0, 5'd7, 5'd0, 32'h12345678, 1'b1, 32'h0,  32'hDEADBEEF, 32'h0,  32'hDEADBEEF};
    tbl[5] = '{5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 32'h0,        32'h0,  32'h0,  32'h0};
    tbl[6] = '{5'd5, 5'd5, 5'd5, 32'h55,       1'b1, 32'h55,       32'h55, 32'h6,  32'h6};
    tbl[7] = '{5'd5, 5'd6, 5'd0, 32'h0,        1'b0, 32'h55,       32'hA,  32'h55, 32'hA};

    set_in(5'd3, 5'd5, 5'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", {31'd0, bus0.ready}, 32'd0);
    chk("rst_rd", bus0.RD[31:0] | bus0.RD[63:32], 32'd0);

    @(negedge CLK);
    rst = 1'b0;
    count_ready(c0, c1);
    chk("ready_after_rst_byp", c0, 32'd31);
    chk("ready_after_rst_nob", c1, 32'd31);
    for (int r = 1; r < 32; r++) rd_chk($sformatf("init_zero_r%0d", r), 5'(r), 32'd0);

    // Table-driven RUN-mode vectors; expectations go through the scoreboard.
    foreach (tbl[i]) begin
      @(negedge CLK);
      set_in(tbl[i].a0, tbl[i].a1, tbl[i].a3, tbl[i].wd, tbl[i].we, 1'b0);
      sb.push_back('{tbl[i].e0, tbl[i].e1, tbl[i].n0, tbl[i].n1});
      #2;
      if (sb.size() == 0) begin
        chk($sformatf("sb_empty_v%0d", i), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_byp_p0", i), bus0.RD[31:0],  e.e0);
        chk($sformatf("vec%0d_byp_p1", i), bus0.RD[63:32], e.e1);
        chk($sformatf("vec%0d_nob_p0", i), bus1.RD[31:0],  e.n0);
        chk($sformatf("vec%0d_nob_p1", i), bus1.RD[63:32], e.n1);
      end
    end

    // Fill, then clear request colliding with a write to register 3.
    for (int r = 1; r < 32; r++) wr(5'(r), 32'hA500_0000 | r);
    rd_chk("fill_r3", 5'd3, 32'hA500_0003);
    rd_chk("fill_r31", 5'd31, 32'hA500_001F);
    @(negedge CLK);
    set_in(5'd7, 5'd7, 5'd3, 32'hFFFF_FFFF, 1'b1, 1'b1);
    @(posedge CLK);
    #1;
    set_in(5'd7, 5'd7, 5'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("clr_ready_low", {31'd0, bus0.ready}, 32'd0);
    chk("clr_rd_zero", bus0.RD[31:0], 32'd0);
    count_ready(c0, c1);
    chk("ready_after_clr_byp", c0, 32'd31);
    chk("ready_after_clr_nob", c1, 32'd31);
    for (int r = 1; r < 32; r++) rd_chk($sformatf("clr_zero_r%0d", r), 5'(r), 32'd0);

    // Reset landing mid-sweep (ptr at 15) must restart a full sweep.
    wr(5'd20, 32'h0000_0020);
    rd_chk("pre_rst_r20", 5'd20, 32'h0000_0020);
    @(negedge CLK);
    set_in(5'd20, 5'd20, 5'd0, 32'd0, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    set_in(5'd20, 5'd20, 5'd0, 32'd0, 1'b0, 1'b0);
    repeat (14) @(posedge CLK);
    @(negedge CLK);
    rst = 1'b1;
    #2;
    chk("midrst_ready", {31'd0, bus0.ready}, 32'd0);
    chk("midrst_rd", bus0.RD[31:0], 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    rst = 1'b0;
    count_ready(c0, c1);
    chk("ready_after_midrst_byp", c0, 32'd31);
    chk("ready_after_midrst_nob", c1, 32'd31);
    rd_chk("post_sweep_r20", 5'd20, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
